// File: rtl/servo_test_sequencer_if.sv
// Command handshake bundle for the servo test sequencer: one command at a time,
// accepted on cmd_valid && cmd_ready.
interface servo_test_sequencer_if #(
   parameter int NUM_SERVOS = 5,
   parameter int POS_WIDTH  = 10
);
   localparam int CH_W = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [CH_W-1:0]      cmd_channel;
   logic [POS_WIDTH-1:0] cmd_position;
   logic                 cmd_ramp;
   logic                 cmd_park;

   modport master (
      output cmd_valid,
      output cmd_channel,
      output cmd_position,
      output cmd_ramp,
      output cmd_park,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_channel,
      input  cmd_position,
      input  cmd_ramp,
      input  cmd_park,
      output cmd_ready
   );
endinterface

// File: rtl/servo_test_sequencer.sv
// Servo test sequencer for dispenser maintenance mode. Executes one command at a
// time: immediate move, slew-limited ramp, or park-all. Drives per-channel
// select/position words to the PWM servo drivers, holds for a settle time and
// then pulses done. Out-of-range channels are rejected with a cmd_error pulse.
module servo_test_sequencer #(
   parameter int                                NUM_SERVOS     = 5,
   parameter int                                POS_WIDTH      = 10,
   parameter logic [POS_WIDTH-1:0]              POS_MIN        = POS_WIDTH'(160),
   parameter logic [POS_WIDTH-1:0]              POS_MAX        = POS_WIDTH'(800),
   parameter logic [NUM_SERVOS*POS_WIDTH-1:0]   PARK_POSITIONS = {NUM_SERVOS{POS_WIDTH'(355)}},
   parameter int unsigned                       HOLD_CYCLES    = 25_000_000,
   parameter int unsigned                       STEP_CYCLES    = 50_000,
   parameter int unsigned                       STEP_SIZE      = 5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   servo_test_sequencer_if.slave           cmdIf,
   output logic [NUM_SERVOS-1:0]           select,
   output logic [NUM_SERVOS*POS_WIDTH-1:0] position,
   output logic                            busy,
   output logic                            done,
   output logic                            cmd_error
);

   localparam int CH_W = (NUM_SERVOS > 1) ? $clog2(NUM_SERVOS) : 1;

   // Terminal counts; a zero-length interval ends on the first counted edge.
   localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);
   localparam logic [31:0] STEP_LAST = (STEP_CYCLES == 0) ? 32'd0 : 32'(STEP_CYCLES - 1);
   localparam logic [31:0] NUM_LIMIT = 32'(NUM_SERVOS);
   localparam logic [POS_WIDTH-1:0] STEP_MAX = POS_WIDTH'(STEP_SIZE);

   typedef enum logic [2:0] {
      IDLE,
      MOVE,
      RAMP,
      HOLD,
      PARK
   } stateT;

   stateT                state, stateNext;
   logic [31:0]          cnt, cntNext;
   logic                 doneNext, errNext;
   logic                 acceptCh, acceptPark, stepEn, parkEnd;

   logic [POS_WIDTH-1:0] posReg [NUM_SERVOS];
   logic [NUM_SERVOS-1:0] selReg;
   logic [CH_W-1:0]      chReg;
   logic [POS_WIDTH-1:0] tgtReg;

   logic [POS_WIDTH-1:0] reqTgt, reqCur, curPos, stepPos;
   logic                 chanBad;

   // Saturate a requested position into the legal mechanical range.
   function automatic logic [POS_WIDTH-1:0] clampPos(input logic [POS_WIDTH-1:0] p);
      if (p < POS_MIN) begin
         return POS_MIN;
      end else if (p > POS_MAX) begin
         return POS_MAX;
      end else begin
         return p;
      end
   endfunction

   // One slew-limited step toward the target. The magnitude is taken only after
   // deciding direction, so the unsigned difference can never wrap.
   function automatic logic [POS_WIDTH-1:0] rampStep(input logic [POS_WIDTH-1:0] cur,
                                                     input logic [POS_WIDTH-1:0] tgt);
      logic [POS_WIDTH-1:0] gap;
      if (tgt > cur) begin
         gap = tgt - cur;
         return (gap > STEP_MAX) ? (cur + STEP_MAX) : tgt;
      end else begin
         gap = cur - tgt;
         return (gap > STEP_MAX) ? (cur - STEP_MAX) : tgt;
      end
   endfunction

   assign reqTgt  = clampPos(cmdIf.cmd_position);
   assign reqCur  = posReg[cmdIf.cmd_channel];
   assign chanBad = 32'(cmdIf.cmd_channel) >= NUM_LIMIT;
   assign curPos  = posReg[chReg];
   assign stepPos = rampStep(curPos, tgtReg);

   assign cmdIf.cmd_ready = (state == IDLE);
   assign busy            = (state != IDLE);
   assign select          = selReg;

   // Next-state, interval counter and pulse decisions for the sequencer.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      doneNext   = 1'b0;
      errNext    = 1'b0;
      acceptCh   = 1'b0;
      acceptPark = 1'b0;
      stepEn     = 1'b0;
      parkEnd    = 1'b0;
      case (state)
         IDLE: begin
            cntNext = '0;
            if (cmdIf.cmd_valid) begin
               if (cmdIf.cmd_park) begin
                  acceptPark = 1'b1;
                  stateNext  = PARK;
               end else if (chanBad) begin
                  errNext = 1'b1;
               end else begin
                  acceptCh = 1'b1;
                  if (!cmdIf.cmd_ramp) begin
                     stateNext = MOVE;
                  end else if (reqTgt == reqCur) begin
                     stateNext = HOLD;
                  end else begin
                     stateNext = RAMP;
                  end
               end
            end
         end
         MOVE: begin
            cntNext   = '0;
            stateNext = HOLD;
         end
         RAMP: begin
            if (cnt == STEP_LAST) begin
               stepEn  = 1'b1;
               cntNext = '0;
               if (stepPos == tgtReg) begin
                  stateNext = HOLD;
               end
            end else begin
               cntNext = cnt + 32'd1;
            end
         end
         HOLD: begin
            if (cnt == HOLD_LAST) begin
               doneNext  = 1'b1;
               cntNext   = '0;
               stateNext = IDLE;
            end else begin
               cntNext = cnt + 32'd1;
            end
         end
         PARK: begin
            if (cnt == HOLD_LAST) begin
               doneNext  = 1'b1;
               parkEnd   = 1'b1;
               cntNext   = '0;
               stateNext = IDLE;
            end else begin
               cntNext = cnt + 32'd1;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // State, interval counter and the registered done/error pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         done      <= 1'b0;
         cmd_error <= 1'b0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         done      <= doneNext;
         cmd_error <= errNext;
      end
   end

   // Channel positions, driver enables and the latched command; reset parks every channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SERVOS; i++) begin
            posReg[i] <= PARK_POSITIONS[i*POS_WIDTH +: POS_WIDTH];
         end
         selReg <= '0;
         chReg  <= '0;
         tgtReg <= '0;
      end else begin
         if (acceptPark) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
               posReg[i] <= PARK_POSITIONS[i*POS_WIDTH +: POS_WIDTH];
            end
            selReg <= '1;
         end else if (acceptCh) begin
            chReg                       <= cmdIf.cmd_channel;
            tgtReg                      <= reqTgt;
            selReg[cmdIf.cmd_channel]   <= 1'b1;
            if (!cmdIf.cmd_ramp) begin
               posReg[cmdIf.cmd_channel] <= reqTgt;
            end
         end
         if (stepEn) begin
            posReg[chReg] <= stepPos;
         end
         if (parkEnd) begin
            selReg <= '0;
         end
      end
   end

   // Flatten the per-channel positions onto the driver bus, channel 0 in the LSBs.
   always_comb begin
      position = '0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
         position[i*POS_WIDTH +: POS_WIDTH] = posReg[i];
      end
   end

endmodule

// File: tb/tb_servo_test_sequencer.sv
// Self-checking bench for servo_test_sequencer with a schedule-level reference model.
module tb_servo_test_sequencer;
   localparam int NS     = 5;
   localparam int PW     = 10;
   localparam int H      = 10;
   localparam int S      = 4;
   localparam int SZ     = 50;
   localparam int PMIN   = 160;
   localparam int PMAX   = 800;
   localparam int PARKV  = 355;
   localparam int MAXOFF = 80;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NS-1:0]        select;
   logic [NS*PW-1:0]     position;
   logic                 busy, done, cmd_error;

   servo_test_sequencer_if #(.NUM_SERVOS(NS), .POS_WIDTH(PW)) cmdBus ();

   servo_test_sequencer #(
      .NUM_SERVOS(NS), .POS_WIDTH(PW), .POS_MIN(10'd160), .POS_MAX(10'd800),
      .PARK_POSITIONS({NS{10'd355}}), .HOLD_CYCLES(H), .STEP_CYCLES(S), .STEP_SIZE(SZ)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmdIf(cmdBus), .select(select),
      .position(position), .busy(busy), .done(done), .cmd_error(cmd_error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what each channel should hold after the last command.
   int            modelPos [NS];
   logic [NS-1:0] modelSel;

   // Expected and observed per-cycle schedule of one command (offset 0 = after accept edge).
   logic [NS*PW-1:0] expPos [MAXOFF];
   logic [NS-1:0]    expSel [MAXOFF];
   logic             expDone[MAXOFF], expErr[MAXOFF], expBusy[MAXOFF];
   logic [NS*PW-1:0] obsPos [MAXOFF];
   logic [NS-1:0]    obsSel [MAXOFF];
   logic             obsDone[MAXOFF], obsErr[MAXOFF], obsBusy[MAXOFF], obsReady[MAXOFF];
   int               span;

   function automatic logic [NS*PW-1:0] packModel();
      logic [NS*PW-1:0] v;
      for (int i = 0; i < NS; i++) v[i*PW +: PW] = PW'(modelPos[i]);
      return v;
   endfunction

   function automatic void record(input int o, input logic d, input logic e, input logic b);
      expPos[o]  = packModel();
      expSel[o]  = modelSel;
      expDone[o] = d;
      expErr[o]  = e;
      expBusy[o] = b;
   endfunction

   // Builds the expected cycle-by-cycle schedule of one command and advances the model.
   task automatic predict(input int ch, input int pos, input bit ramp, input bit park);
      int tgt, cur, d, doneOff;
      int stepVals[$];
      if (park) begin
         for (int i = 0; i < NS; i++) modelPos[i] = PARKV;
         modelSel = '1;
         doneOff  = H;
         for (int o = 0; o <= doneOff; o++) begin
            if (o == doneOff) modelSel = '0;
            record(o, o == doneOff, 1'b0, o != doneOff);
         end
         span = doneOff + 1;
         return;
      end
      if (ch >= NS) begin
         record(0, 1'b0, 1'b1, 1'b0);
         span = 1;
         return;
      end
      tgt = (pos < PMIN) ? PMIN : ((pos > PMAX) ? PMAX : pos);
      modelSel[ch] = 1'b1;
      if (!ramp) begin
         modelPos[ch] = tgt;
         doneOff = 1 + H;
      end else begin
         cur = modelPos[ch];
         while (cur != tgt) begin
            d = tgt - cur;
            if (d > SZ) d = SZ;
            if (d < -SZ) d = -SZ;
            cur += d;
            stepVals.push_back(cur);
         end
         doneOff = stepVals.size() * S + H;
      end
      for (int o = 0; o <= doneOff; o++) begin
         if (ramp && o > 0 && (o % S) == 0 && (o / S) <= stepVals.size())
            modelPos[ch] = stepVals[o/S - 1];
         record(o, o == doneOff, 1'b0, o != doneOff);
      end
      span = doneOff + 1;
   endtask

   // Presents one command, then samples the outputs for span cycles. With poke set,
   // unrelated commands are offered while the sequencer is busy.
   task automatic issueAndCapture(input int ch, input int pos, input bit ramp, input bit park,
                                  input bit poke);
      cmdBus.cmd_channel  = 3'(ch);
      cmdBus.cmd_position = PW'(pos);
      cmdBus.cmd_ramp     = ramp;
      cmdBus.cmd_park     = park;
      cmdBus.cmd_valid    = 1'b1;
      @(posedge clk); #1;
      cmdBus.cmd_valid = 1'b0;
      for (int o = 0; o < span; o++) begin
         if (poke && span > 8 && o == 2) begin
            cmdBus.cmd_channel  = 3'($urandom_range(0, 7));
            cmdBus.cmd_position = PW'($urandom_range(0, 1023));
            cmdBus.cmd_ramp     = 1'($urandom_range(0, 1));
            cmdBus.cmd_park     = 1'($urandom_range(0, 1));
            cmdBus.cmd_valid    = 1'b1;
         end
         if (poke && span > 8 && o == 6) cmdBus.cmd_valid = 1'b0;
         obsPos[o]   = position;
         obsSel[o]   = select;
         obsDone[o]  = done;
         obsErr[o]   = cmd_error;
         obsBusy[o]  = busy;
         obsReady[o] = cmdBus.cmd_ready;
         if (o < span - 1) begin
            @(posedge clk); #1;
         end
      end
      cmdBus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmdBus.cmd_valid = 1'b0; cmdBus.cmd_channel = '0; cmdBus.cmd_position = '0;
      cmdBus.cmd_ramp = 1'b0; cmdBus.cmd_park = 1'b0;
      for (int i = 0; i < NS; i++) modelPos[i] = PARKV;
      modelSel = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (position !== {NS{10'd355}}) begin
         failures++; $display("FAIL reset_position got %h want %h", position, {NS{10'd355}});
      end
      checks++;
      if (select !== 5'b00000) begin
         failures++; $display("FAIL reset_select got %b want 00000", select);
      end
      checks++;
      if ({cmdBus.cmd_ready, busy, done, cmd_error} !== 4'b1000) begin
         failures++; $display("FAIL reset_status ready/busy/done/err got %b want 1000",
                              {cmdBus.cmd_ready, busy, done, cmd_error});
      end
   endtask

   task automatic test_move();
      predict(2, 800, 1'b0, 1'b0);
      issueAndCapture(2, 800, 1'b0, 1'b0, 1'b0);
      for (int o = 0; o < span; o++) begin
         checks++;
         if (obsPos[o] !== expPos[o] || obsSel[o] !== expSel[o]) begin
            failures++; $display("FAIL move_outputs off=%0d got pos=%h sel=%b want pos=%h sel=%b",
                                 o, obsPos[o], obsSel[o], expPos[o], expSel[o]);
         end
         checks++;
         if ({obsDone[o], obsErr[o], obsBusy[o], obsReady[o]} !== {expDone[o], expErr[o], expBusy[o], ~expBusy[o]}) begin
            failures++; $display("FAIL move_status off=%0d got done/err/busy/ready=%b want %b", o,
                                 {obsDone[o], obsErr[o], obsBusy[o], obsReady[o]},
                                 {expDone[o], expErr[o], expBusy[o], ~expBusy[o]});
         end
      end
      checks++;
      if (obsPos[0][2*PW +: PW] !== 10'd800 || obsSel[0][2] !== 1'b1 || obsDone[11] !== 1'b1) begin
         failures++; $display("FAIL move_ch2 got pos2=%0d sel2=%b done@11=%b want 800 1 1",
                              obsPos[0][2*PW +: PW], obsSel[0][2], obsDone[11]);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || select[2] !== 1'b1) begin
         failures++; $display("FAIL move_after_done got done=%b sel2=%b want 0 1", done, select[2]);
      end
   endtask

   task automatic test_clamp();
      int req[2]  = '{1000, 50};
      int want[2] = '{800, 160};
      for (int c = 0; c < 2; c++) begin
         predict(1, req[c], 1'b0, 1'b0);
         issueAndCapture(1, req[c], 1'b0, 1'b0, 1'b0);
         for (int o = 0; o < span; o++) begin
            checks++;
            if (obsPos[o] !== expPos[o] || obsSel[o] !== expSel[o]) begin
               failures++; $display("FAIL clamp_outputs off=%0d got pos=%h sel=%b want pos=%h sel=%b",
                                    o, obsPos[o], obsSel[o], expPos[o], expSel[o]);
            end
            checks++;
            if ({obsDone[o], obsErr[o], obsBusy[o], obsReady[o]} !== {expDone[o], expErr[o], expBusy[o], ~expBusy[o]}) begin
               failures++; $display("FAIL clamp_status off=%0d got done/err/busy/ready=%b want %b", o,
                                    {obsDone[o], obsErr[o], obsBusy[o], obsReady[o]},
                                    {expDone[o], expErr[o], expBusy[o], ~expBusy[o]});
            end
         end
         checks++;
         if (obsPos[0][PW +: PW] !== PW'(want[c])) begin
            failures++; $display("FAIL clamp_ch1 req=%0d got %0d want %0d", req[c], obsPos[0][PW +: PW], want[c]);
         end
      end
   endtask

   task automatic test_ramp();
      int seq[4] = '{305, 255, 205, 160};
      for (int c = 0; c < 2; c++) begin
         predict(0, 160, 1'b1, 1'b0);
         issueAndCapture(0, 160, 1'b1, 1'b0, 1'b0);
         for (int o = 0; o < span; o++) begin
            checks++;
            if (obsPos[o] !== expPos[o] || obsSel[o] !== expSel[o]) begin
               failures++; $display("FAIL ramp_outputs off=%0d got pos=%h sel=%b want pos=%h sel=%b",
                                    o, obsPos[o], obsSel[o], expPos[o], expSel[o]);
            end
            checks++;
            if ({obsDone[o], obsErr[o], obsBusy[o], obsReady[o]} !== {expDone[o], expErr[o], expBusy[o], ~expBusy[o]}) begin
               failures++; $display("FAIL ramp_status off=%0d got done/err/busy/ready=%b want %b", o,
                                    {obsDone[o], obsErr[o], obsBusy[o], obsReady[o]},
                                    {expDone[o], expErr[o], expBusy[o], ~expBusy[o]});
            end
         end
         if (c == 0) begin
            for (int k = 0; k < 4; k++) begin
               checks++;
               if (obsPos[4*(k+1)][PW-1:0] !== PW'(seq[k]) || obsPos[4*(k+1)-1][PW-1:0] === PW'(seq[k])) begin
                  failures++; $display("FAIL ramp_step%0d got %0d (prev %0d) want %0d", k,
                                       obsPos[4*(k+1)][PW-1:0], obsPos[4*(k+1)-1][PW-1:0], seq[k]);
               end
            end
            checks++;
            if (obsDone[26] !== 1'b1) begin
               failures++; $display("FAIL ramp_done_time got done@26=%b want 1", obsDone[26]);
            end
         end else begin
            checks++;
            if (span != H + 1 || obsDone[H] !== 1'b1) begin
               failures++; $display("FAIL ramp_equal_hold got done@%0d=%b want 1", H, obsDone[H]);
            end
         end
      end
   endtask

   task automatic test_error();
      int badCh[2] = '{6, 7};
      for (int c = 0; c < 2; c++) begin
         predict(badCh[c], 500, 1'b0, 1'b0);
         issueAndCapture(badCh[c], 500, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obsPos[0] !== expPos[0] || obsSel[0] !== expSel[0]) begin
            failures++; $display("FAIL error_outputs got pos=%h sel=%b want pos=%h sel=%b",
                                 obsPos[0], obsSel[0], expPos[0], expSel[0]);
         end
         checks++;
         if ({obsDone[0], obsErr[0], obsBusy[0], obsReady[0]} !== 4'b0101) begin
            failures++; $display("FAIL error_pulse ch=%0d got done/err/busy/ready=%b want 0101", badCh[c],
                                 {obsDone[0], obsErr[0], obsBusy[0], obsReady[0]});
         end
         @(posedge clk); #1;
         checks++;
         if ({done, cmd_error, busy, cmdBus.cmd_ready} !== 4'b0001 || position !== expPos[0]) begin
            failures++; $display("FAIL error_one_cycle got done/err/busy/ready=%b want 0001",
                                 {done, cmd_error, busy, cmdBus.cmd_ready});
         end
      end
   endtask

   task automatic test_busy_ignore();
      int ch[2]  = '{4, 3};
      int pos[2] = '{300, 620};
      for (int c = 0; c < 2; c++) begin
         predict(ch[c], pos[c], 1'(c == 0), 1'b0);
         issueAndCapture(ch[c], pos[c], 1'(c == 0), 1'b0, 1'b1);
         for (int o = 0; o < span; o++) begin
            checks++;
            if (obsPos[o] !== expPos[o] || obsSel[o] !== expSel[o]) begin
               failures++; $display("FAIL busy_outputs off=%0d got pos=%h sel=%b want pos=%h sel=%b",
                                    o, obsPos[o], obsSel[o], expPos[o], expSel[o]);
            end
            checks++;
            if ({obsDone[o], obsErr[o], obsBusy[o], obsReady[o]} !== {expDone[o], expErr[o], expBusy[o], ~expBusy[o]}) begin
               failures++; $display("FAIL busy_status off=%0d got done/err/busy/ready=%b want %b", o,
                                    {obsDone[o], obsErr[o], obsBusy[o], obsReady[o]},
                                    {expDone[o], expErr[o], expBusy[o], ~expBusy[o]});
            end
         end
      end
   endtask

   task automatic test_park();
      predict(0, 0, 1'b0, 1'b1);
      issueAndCapture(0, 0, 1'b0, 1'b1, 1'b0);
      for (int o = 0; o < span; o++) begin
         checks++;
         if (obsPos[o] !== expPos[o] || obsSel[o] !== expSel[o]) begin
            failures++; $display("FAIL park_outputs off=%0d got pos=%h sel=%b want pos=%h sel=%b",
                                 o, obsPos[o], obsSel[o], expPos[o], expSel[o]);
         end
         checks++;
         if ({obsDone[o], obsErr[o], obsBusy[o], obsReady[o]} !== {expDone[o], expErr[o], expBusy[o], ~expBusy[o]}) begin
            failures++; $display("FAIL park_status off=%0d got done/err/busy/ready=%b want %b", o,
                                 {obsDone[o], obsErr[o], obsBusy[o], obsReady[o]},
                                 {expDone[o], expErr[o], expBusy[o], ~expBusy[o]});
         end
      end
      checks++;
      if (obsSel[9] !== 5'b11111 || obsSel[10] !== 5'b00000 || obsPos[0] !== {NS{10'd355}}) begin
         failures++; $display("FAIL park_window got sel@9=%b sel@10=%b pos=%h want 11111 00000 all 355",
                              obsSel[9], obsSel[10], obsPos[0]);
      end
   endtask

   task automatic test_back_to_back();
      int ch, pos;
      bit ramp, park, poke;
      for (int c = 0; c < 16; c++) begin
         ch   = $urandom_range(0, 6);
         pos  = $urandom_range(0, 1023);
         ramp = 1'($urandom_range(0, 1));
         park = ($urandom_range(0, 7) == 0);
         poke = 1'($urandom_range(0, 1));
         predict(ch, pos, ramp, park);
         issueAndCapture(ch, pos, ramp, park, poke);
         for (int o = 0; o < span; o++) begin
            checks++;
            if (obsPos[o] !== expPos[o] || obsSel[o] !== expSel[o]) begin
               failures++; $display("FAIL random_outputs cmd=%0d off=%0d got pos=%h sel=%b want pos=%h sel=%b",
                                    c, o, obsPos[o], obsSel[o], expPos[o], expSel[o]);
            end
            checks++;
            if ({obsDone[o], obsErr[o], obsBusy[o], obsReady[o]} !== {expDone[o], expErr[o], expBusy[o], ~expBusy[o]}) begin
               failures++; $display("FAIL random_status cmd=%0d off=%0d got done/err/busy/ready=%b want %b", c, o,
                                    {obsDone[o], obsErr[o], obsBusy[o], obsReady[o]},
                                    {expDone[o], expErr[o], expBusy[o], ~expBusy[o]});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      cmdBus.cmd_channel = 3'd3; cmdBus.cmd_position = 10'd500;
      cmdBus.cmd_ramp = 1'b0; cmdBus.cmd_park = 1'b0; cmdBus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmdBus.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < NS; i++) modelPos[i] = PARKV;
      modelSel = '0;
      checks++;
      if (position !== packModel() || select !== modelSel ||
          {cmdBus.cmd_ready, busy, done, cmd_error} !== 4'b1000) begin
         failures++; $display("FAIL reset_mid_async got pos=%h sel=%b rbde=%b want pos=%h sel=00000 1000",
                              position, select, {cmdBus.cmd_ready, busy, done, cmd_error}, packModel());
      end
      @(posedge clk); #1;
      checks++;
      if (position !== packModel() || select !== modelSel ||
          {cmdBus.cmd_ready, busy, done, cmd_error} !== 4'b1000) begin
         failures++; $display("FAIL reset_mid_next got pos=%h sel=%b rbde=%b want pos=%h sel=00000 1000",
                              position, select, {cmdBus.cmd_ready, busy, done, cmd_error}, packModel());
      end
      rst_n = 1'b1;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_mid_no_done cyc=%0d got done=%b busy=%b want 0 0", c, done, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_move();
      test_clamp();
      test_ramp();
      test_error();
      test_busy_ignore();
      test_park();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
